// File: rtl/vram_readout.sv
// -----------------------------------------------------------------------------
// vram_readout
//
// Text-mode VRAM readout stage. It sits directly upstream of the pixel
// generator. From the timing generator's hCount/vCount it walks the character
// cells of each displayed scanline. For each cell it fetches the character
// byte (address 2n) and then the attribute byte (address 2n+1) from a
// synchronous VRAM. It presents the fetched bytes on readoutData together with
// the 8-phase readoutCount and the active qualifier.
//
// Per-cell phase map while active (readoutCount value):
//   1..4 : vramAddr holds the char address  (VRAM samples it at end of 1)
//   5..0 : vramAddr holds the attr address  (VRAM samples it at end of 5)
//   3    : readoutData = char byte          (captured at end of 2)
//   7    : readoutData = attr byte          (captured at end of 6)
//
// Ports
//   clk          in   1         pixel clock
//   nrst         in   1         asynchronous active-low reset
//   hCount       in   10        horizontal pixel count
//   vCount       in   10        scanline count
//   vramRdData   in   8         VRAM read data (valid one cycle after address)
//   scrollBase   in   ADDR_W-1  frame-start cell offset (VRAM_SCROLL_EN only)
//   vramAddr     out  ADDR_W    registered VRAM read address
//   readoutData  out  8         registered fetched byte
//   readoutCount out  3         free-running cell phase 0..7
//   active       out  1         high while a displayed line is read out
//
// Configuration
//   VRAM_SCROLL_EN : when defined, adds scrollBase. It is loaded into the row
//                    base at frame start (hCount==0 && vCount==0) for hardware
//                    scrolling. When undefined, the frame-start row base is 0.
// -----------------------------------------------------------------------------
module vram_readout #(
  parameter int COLS        = 80,
  parameter int ROWS        = 25,
  parameter int H_ACT_START = 152,
  parameter int ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [9:0]        hCount,
  input  logic [9:0]        vCount,
  input  logic [7:0]        vramRdData,
`ifdef VRAM_SCROLL_EN
  input  logic [ADDR_W-2:0] scrollBase,
`endif
  output logic [ADDR_W-1:0] vramAddr,
  output logic [7:0]        readoutData,
  output logic [2:0]        readoutCount,
  output logic              active
);

  localparam int IDX_W = ADDR_W - 1;
  localparam int COL_W = $clog2(COLS);

  localparam logic [9:0]       H_REALIGN = 10'(H_ACT_START - 1);
  localparam logic [9:0]       V_LINES   = 10'(16 * ROWS);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  localparam logic [IDX_W-1:0] ROW_STEP  = IDX_W'(COLS);

  logic [2:0]        count_q,    count_d;
  logic              active_q,   active_d;
  logic [COL_W-1:0]  col_q,      col_d;
  logic [IDX_W-1:0]  row_base_q, row_base_d;
  logic              row_step_q, row_step_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [7:0]        data_q,     data_d;

  logic [IDX_W-1:0]  frame_base;
  logic [IDX_W-1:0]  idx;
  logic              realign;
  logic              frame_start;
  logic              line_valid;

`ifdef VRAM_SCROLL_EN
  assign frame_base = scrollBase;
`else
  assign frame_base = '0;
`endif

  // Cell index wraps modulo 2^(ADDR_W-1); no overflow flag is wanted.
  assign idx         = row_base_q + IDX_W'(col_q);
  assign realign     = (hCount == H_REALIGN);
  assign frame_start = (hCount == 10'd0) && (vCount == 10'd0);
  assign line_valid  = (vCount < V_LINES);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    count_d    = count_q + 3'd1;
    active_d   = active_q;
    col_d      = col_q;
    row_base_d = row_base_q;
    row_step_d = row_step_q;
    addr_d     = addr_q;
    data_d     = data_q;

    if (realign) begin
      // Line start: phase realigns to 0. Line validity and the row-step
      // decision are captured here, so later vCount changes are ignored.
      count_d    = 3'd0;
      active_d   = line_valid;
      col_d      = '0;
      row_step_d = (vCount[3:0] == 4'hF);
    end else if (active_q) begin
      case (count_q)
        3'd0: addr_d = {idx, 1'b0};        // entering count 1: char address
        3'd4: addr_d = {idx, 1'b1};        // entering count 5: attr address
        3'd2,
        3'd6: data_d = vramRdData;         // char/attr valid in counts 3/7
        3'd7: begin
          if (col_q == COL_LAST) begin
            // Last cell done: stop before fetching cell COLS.
            col_d    = '0;
            active_d = 1'b0;
            if (row_step_q) begin
              row_base_d = row_base_q + ROW_STEP;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Frame start has priority over the end-of-line row step.
    if (frame_start) begin
      row_base_d = frame_base;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q    <= '0;
      active_q   <= 1'b0;
      col_q      <= '0;
      row_base_q <= '0;
      row_step_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      count_q    <= count_d;
      active_q   <= active_d;
      col_q      <= col_d;
      row_base_q <= row_base_d;
      row_step_q <= row_step_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign vramAddr     = addr_q;
  assign readoutData  = data_q;
  assign readoutCount = count_q;
  assign active       = active_q;

endmodule

// File: tb/tb_vram_readout.sv
// -----------------------------------------------------------------------------
// tb_vram_readout
//
// Bench for vram_readout. It drives whole scanlines (hCount 0..799) with
// chosen vCount values and models a synchronous VRAM. A scoreboard queue holds
// the expected char/attr fetches for every cell of each valid line. A per-line
// table gives the expected active length, address activity and first/last
// addresses. An independent model of the free-running phase counter is
// checked every cycle.
// -----------------------------------------------------------------------------
module tb_vram_readout;

  localparam int H_TOTAL = 800;
  localparam int H_START = 152;
  localparam int NCOLS   = 80;
  localparam int IDX_MOD = 2048;

`ifdef VRAM_SCROLL_EN
  localparam int BASE = 1990;
  logic [10:0] scroll_base;
`else
  localparam int BASE = 0;
`endif

  logic        clk;
  logic        nrst;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic [7:0]  vramRdData;
  logic [11:0] vramAddr;
  logic [7:0]  readoutData;
  logic [2:0]  readoutCount;
  logic        active;

  vram_readout dut (
    .clk         (clk),
    .nrst        (nrst),
    .hCount      (hCount),
    .vCount      (vCount),
    .vramRdData  (vramRdData),
`ifdef VRAM_SCROLL_EN
    .scrollBase  (scroll_base),
`endif
    .vramAddr    (vramAddr),
    .readoutData (readoutData),
    .readoutCount(readoutCount),
    .active      (active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous VRAM: data appears the cycle after the address is sampled.
  logic [7:0] mem [4096];
  always @(posedge clk) vramRdData <= mem[vramAddr];

  // Independent phase model: +1 every clock, 0 after hCount==H_START-1.
  logic [2:0] exp_cnt;
  always @(posedge clk or negedge nrst) begin
    if (!nrst)                    exp_cnt <= 3'd0;
    else if (hCount == H_START-1) exp_cnt <= 3'd0;
    else                          exp_cnt <= exp_cnt + 3'd1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [11:0] char_addr;
    logic [7:0]  char_data;
    logic [11:0] attr_addr;
    logic [7:0]  attr_data;
  } fetch_t;

  fetch_t sb[$];

  typedef struct {
    int vcount;
    int row_base;
    int valid;
    int exp_active;
    int exp_changes;
    int exp_first;
    int exp_last;
  } line_vec_t;

  line_vec_t tbl [9];

  // Per-line statistics collected by the monitor.
  int          act_cycles;
  int          addr_changes;
  bit          first_seen;
  logic [11:0] first_addr;
  logic [7:0]  first_data;
  logic [11:0] prev_addr   = '0;
  logic        prev_active = 1'b0;

  always @(negedge clk) begin
    if (nrst) begin
      check("readout_count", readoutCount, exp_cnt);
      if (active && !prev_active) check("active_rise_at_count0", readoutCount, 0);
      if (active) act_cycles++;
      if (vramAddr != prev_addr) addr_changes++;
      if (active && readoutCount == 3'd3) begin
        check("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          check("char_addr", vramAddr, sb[0].char_addr);
          check("char_data", readoutData, sb[0].char_data);
          if (!first_seen) begin
            first_seen = 1'b1;
            first_addr = vramAddr;
            first_data = readoutData;
          end
        end
      end
      if (active && readoutCount >= 3'd4 && readoutCount <= 3'd6 && sb.size() != 0)
        check("char_hold", readoutData, sb[0].char_data);
      if (active && readoutCount == 3'd7 && sb.size() != 0) begin
        check("attr_addr", vramAddr, sb[0].attr_addr);
        check("attr_data", readoutData, sb[0].attr_data);
        void'(sb.pop_front());
      end
    end
    prev_active = active;
    prev_addr   = vramAddr;
  end

  function automatic int last_attr(input int rb);
    return 2 * ((rb + NCOLS - 1) % IDX_MOD) + 1;
  endfunction

  // Drives hCount 0..stop_h-1 for one scanline; optionally queues the
  // expected fetches of all cells for row base rb.
  task automatic run_line(input int v, input int push, input int rb, input int stop_h);
    for (int h = 0; h < stop_h; h++) begin
      @(posedge clk);
      #1;
      hCount = 10'(h);
      vCount = 10'(v);
      if (h == 0) begin
        act_cycles   = 0;
        addr_changes = 0;
        first_seen   = 1'b0;
        if (push != 0) begin
          for (int c = 0; c < NCOLS; c++) begin
            fetch_t f;
            int     idx;
            idx         = (rb + c) % IDX_MOD;
            f.char_addr = 12'(2 * idx);
            f.attr_addr = 12'(2 * idx + 1);
            f.char_data = mem[2 * idx];
            f.attr_data = mem[2 * idx + 1];
            sb.push_back(f);
          end
        end
      end
    end
  endtask

  initial begin
    int rb0;
    int rb1;
    int first_changes;

    rb0 = BASE % IDX_MOD;
    rb1 = (BASE + NCOLS) % IDX_MOD;
    // After reset vramAddr is 0, so a first char address of 0 is not a change.
    first_changes = (2 * rb0 == 0) ? 159 : 160;

    //            vcount rowbase valid active changes        first    last
    tbl[0] = '{   0,     rb0,    1,    640,   first_changes, 2*rb0,   last_attr(rb0)};
    tbl[1] = '{   1,     rb0,    1,    640,   160,           2*rb0,   last_attr(rb0)};
    tbl[2] = '{  15,     rb0,    1,    640,   160,           2*rb0,   last_attr(rb0)};
    tbl[3] = '{  16,     rb1,    1,    640,   160,           2*rb1,   last_attr(rb1)};
    tbl[4] = '{  17,     rb1,    1,    640,   160,           2*rb1,   last_attr(rb1)};
    tbl[5] = '{ 399,     rb1,    1,    640,   160,           2*rb1,   last_attr(rb1)};
    tbl[6] = '{ 400,     rb1,    0,      0,     0,           0,       last_attr(rb1)};
    tbl[7] = '{ 524,     rb1,    0,      0,     0,           0,       last_attr(rb1)};
    tbl[8] = '{   0,     rb0,    1,    640,   160,           2*rb0,   last_attr(rb0)};

    for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 37 + 5) & 255);
    mem[0] = 8'h41;
    mem[1] = 8'h1F;

`ifdef VRAM_SCROLL_EN
    scroll_base = 11'(BASE);
`endif
    hCount = '0;
    vCount = '0;
    nrst   = 1'b1;
    #2 nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr",   vramAddr, 0);
    check("rst_data",   readoutData, 0);
    check("rst_count",  readoutCount, 0);
    check("rst_active", active, 0);
    nrst = 1'b1;

    // Reset asserted in the middle of a displayed line.
    run_line(0, 1, rb0, 400);
    check("pre_reset_active", active, 1);
    check("pre_reset_addr_nonzero", vramAddr != 12'd0, 1);
    #1 nrst = 1'b0;
    #1;
    check("midrst_addr",   vramAddr, 0);
    check("midrst_data",   readoutData, 0);
    check("midrst_count",  readoutCount, 0);
    check("midrst_active", active, 0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    sb.delete();

    for (int i = 0; i < 9; i++) begin
      run_line(tbl[i].vcount, tbl[i].valid, tbl[i].row_base, H_TOTAL);
      check($sformatf("line%0d_active_cycles", i), act_cycles, tbl[i].exp_active);
      check($sformatf("line%0d_addr_changes", i), addr_changes, tbl[i].exp_changes);
      check($sformatf("line%0d_last_addr", i), vramAddr, tbl[i].exp_last);
      check($sformatf("line%0d_sb_drained", i), sb.size(), 0);
      if (tbl[i].valid != 0) begin
        check($sformatf("line%0d_first_addr", i), first_addr, tbl[i].exp_first);
        check($sformatf("line%0d_first_data", i), first_data, mem[tbl[i].exp_first]);
      end
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
